mdu: RTL

- Execute-stage multiply/divide unit. It sits beside the ALU and is fed by the same forwarded operand muxes (A1 = rs value, A2 = rt value).
- It owns the HI/LO registers and models multi-cycle MULT/DIV latency with a Busy flag, which the D-stage hazard unit uses to stall.
- Its MDUOut output is muxed with the ALU result into the E/M pipeline register.

---
 rtl/mdu.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs MULT/DIV with a fixed
// latency and a Busy flag for the hazard unit.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_res;
  logic          r_wr;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic        w_mult;
  logic        w_multu;
  logic        w_div;
  logic        w_divu;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_launch;
  logic        w_done;
  logic        w_mthi;
  logic        w_mtlo;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_res;
  logic        w_dz;

  assign w_mult   = (MDUOp == OP_MULT);
  assign w_multu  = (MDUOp == OP_MULTU);
  assign w_div    = (MDUOp == OP_DIV);
  assign w_divu   = (MDUOp == OP_DIVU);
  assign w_is_mul = w_mult | w_multu;
  assign w_is_div = w_div | w_divu;

  assign w_launch = Start & ~Req & ~r_busy
                  & (w_is_mul | w_is_div);
  assign w_done   = r_busy & (r_cnt == CW'(1));
  assign w_mthi   = (MDUOp == OP_MTHI) & ~Req & ~r_busy;
  assign w_mtlo   = (MDUOp == OP_MTLO) & ~Req & ~r_busy;

  // One 64x64 multiplier serves both flavours via operand extension.
  assign w_mul_a = w_mult ? {{32{A1[31]}}, A1} : {32'b0, A1};
  assign w_mul_b = w_mult ? {{32{A2[31]}}, A2} : {32'b0, A2};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide runs on magnitudes; INT_MIN/-1 wraps back to INT_MIN.
  assign w_neg_a = w_div & A1[31];
  assign w_neg_b = w_div & A2[31];
  assign w_mag_a = w_neg_a ? (~A1 + 32'd1) : A1;
  assign w_mag_b = w_neg_b ? (~A2 + 32'd1) : A2;
  assign w_dz    = (A2 == 32'd0);
  assign w_den   = w_dz ? 32'd1 : w_mag_b;
  assign w_uq    = w_mag_a / w_den;
  assign w_ur    = w_mag_a % w_den;
  assign w_q     = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
  assign w_r     = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  assign w_res = w_is_mul ? w_prod : {w_r, w_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_wr   <= 1'b0;
    end else if (w_launch) begin
      r_busy <= 1'b1;
      r_cnt  <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      r_res  <= w_res;
      r_wr   <= ~(w_is_div & w_dz);
    end else if (r_busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_done)
        r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (r_wr) begin
        r_hi <= r_res[63:32];
        r_lo <= r_res[31:0];
      end
    end else begin
      if (w_mthi)
        r_hi <= A1;
      if (w_mtlo)
        r_lo <= A1;
    end
  end

  always_comb begin
    MDUOut = 32'd0;
    unique case (1'b1)
      (MDUOp == OP_MFHI): MDUOut = r_hi;
      (MDUOp == OP_MFLO): MDUOut = r_lo;
      default:            MDUOut = 32'd0;
    endcase
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
